// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one sum bit per clock, LSB first, done pulses WIDTH cycles after start; start ignored while busy.
// Optional signed-overflow output ovf is built only when SERIAL_ADD_OVF_EN is defined.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADD,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_opa;
   logic [WIDTH-1:0] r_opb;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;

   logic             w_bit;
   logic             w_carry_nxt;
   logic             w_last;

   assign w_bit       = r_opa[0] ^ r_opb[0] ^ r_carry;
   assign w_carry_nxt = (r_opa[0] & r_opb[0]) | (r_carry & (r_opa[0] ^ r_opb[0]));
   assign w_last      = (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_opa   <= '0;
         r_opb   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf     <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  r_opa   <= a;
                  r_opb   <= b;
                  r_carry <= cin;
                  r_cnt   <= '0;
                  busy    <= 1'b1;
                  r_state <= S_ADD;
`ifdef SERIAL_ADD_OVF_EN
                  ovf     <= 1'b0;
`endif
               end
            end
            S_ADD: begin
               // Sum fills from the MSB end so bit 0 lands in sum[0] after WIDTH shifts.
               sum     <= {w_bit, sum[WIDTH-1:1]};
               r_opa   <= r_opa >> 1;
               r_opb   <= r_opb >> 1;
               r_carry <= w_carry_nxt;
               r_cnt   <= r_cnt + CW'(1);
               if (w_last) begin
                  r_state <= S_DONE;
                  done    <= 1'b1;
                  cout    <= w_carry_nxt;
`ifdef SERIAL_ADD_OVF_EN
                  ovf     <= r_carry ^ w_carry_nxt;
`endif
               end
            end
            S_DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8): directed vectors plus randomized back-to-back operations.
module tb_serial_adder_ctrl;

   logic       clk;
   logic       rst;
   logic       t_start;
   logic [7:0] t_a;
   logic [7:0] t_b;
   logic       t_cin;
   logic       t_busy;
   logic       t_done;
   logic [7:0] t_sum;
   logic       t_cout;
`ifdef SERIAL_ADD_OVF_EN
   logic       t_ovf;
`endif

   int checks = 0;
   int errors = 0;

   // expected word: {ovf, cout, sum}
   logic [9:0] exp_q[$];

   serial_adder_ctrl #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (t_start),
      .a     (t_a),
      .b     (t_b),
      .cin   (t_cin),
      .busy  (t_busy),
      .done  (t_done),
      .sum   (t_sum),
      .cout  (t_cout)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf   (t_ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: compare every done pulse against the oldest expected result
   always @(negedge clk) begin
      if (!rst && t_done === 1'b1) begin
         logic [9:0] e;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: sum=%0h cout=%0b with empty scoreboard", t_sum, t_cout);
         end else begin
            e = exp_q.pop_front();
            check("sum", 32'(t_sum), 32'(e[7:0]));
            check("cout", 32'(t_cout), 32'(e[8]));
`ifdef SERIAL_ADD_OVF_EN
            check("ovf", 32'(t_ovf), 32'(e[9]));
`endif
         end
      end
   end

   // issue a start at a negedge; returns at the first negedge after the start edge
   task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                        input logic [9:0] exp, input bit push);
      @(negedge clk);
      t_start = 1'b1;
      t_a     = av;
      t_b     = bv;
      t_cin   = ci;
      if (push) exp_q.push_back(exp);
      @(negedge clk);
      t_start = 1'b0;
      t_a     = 8'hxx;
      t_b     = 8'hxx;
      t_cin   = 1'bx;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (t_done !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (t_done !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: done not seen within 30 cycles", name);
      end
   endtask

   function automatic logic [9:0] ref_add(input logic [7:0] av, input logic [7:0] bv, input logic ci);
      logic [8:0] s;
      logic       o;
      s = {1'b0, av} + {1'b0, bv} + {8'b0, ci};
      o = (av[7] == bv[7]) && (s[7] != av[7]);
      return {o, s[8:0]};
   endfunction

   initial begin
      int first_done;
      int busy_cnt;
      int done_cnt;
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;

      rst     = 1'b1;
      t_start = 1'b0;
      t_a     = 8'h00;
      t_b     = 8'h00;
      t_cin   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(t_busy), 0);
      check("rst_done", 32'(t_done), 0);
      check("rst_sum", 32'(t_sum), 0);
      check("rst_cout", 32'(t_cout), 0);
`ifdef SERIAL_ADD_OVF_EN
      check("rst_ovf", 32'(t_ovf), 0);
`endif
      rst = 1'b0;

      // 5A+3C: latency and busy width; k counts negedges after the start edge
      issue(8'h5A, 8'h3C, 1'b0, {1'b1, 1'b0, 8'h96}, 1'b1);
      first_done = 0;
      busy_cnt   = 0;
      for (int k = 1; k <= 12; k++) begin
         if (t_busy === 1'b1) busy_cnt++;
         if (t_done === 1'b1 && first_done == 0) first_done = k;
         if (k == 12) check("sum_held_idle", 32'(t_sum), 32'h96);
         @(negedge clk);
      end
      check("done_latency", 32'(first_done), 9);
      check("busy_cycles", 32'(busy_cnt), 9);

      issue(8'hFF, 8'h01, 1'b0, {1'b0, 1'b1, 8'h00}, 1'b1);
      wait_done("ff_plus_1");
      issue(8'h00, 8'h00, 1'b1, {1'b0, 1'b0, 8'h01}, 1'b1);
      wait_done("cin_only");
      issue(8'h7F, 8'h01, 1'b0, {1'b1, 1'b0, 8'h80}, 1'b1);
      wait_done("pos_ovf");
      issue(8'h80, 8'hFF, 1'b0, {1'b1, 1'b1, 8'h7F}, 1'b1);
      wait_done("neg_ovf");

      // start during ADD must be ignored
      issue(8'h5A, 8'h3C, 1'b0, {1'b1, 1'b0, 8'h96}, 1'b1);
      @(negedge clk);
      @(negedge clk);
      t_start = 1'b1;
      t_a     = 8'hFF;
      t_b     = 8'hFF;
      t_cin   = 1'b1;
      @(negedge clk);
      t_start  = 1'b0;
      done_cnt = 0;
      for (int k = 4; k <= 14; k++) begin
         if (t_done === 1'b1) done_cnt++;
         @(negedge clk);
      end
      check("ignored_start_done_count", 32'(done_cnt), 1);

      // reset mid-ADD discards the operation
      issue(8'hA5, 8'h5A, 1'b1, 10'h0, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", 32'(t_busy), 0);
      check("midrst_done", 32'(t_done), 0);
      check("midrst_sum", 32'(t_sum), 0);
      check("midrst_cout", 32'(t_cout), 0);
      issue(8'h12, 8'h34, 1'b0, {1'b0, 1'b0, 8'h46}, 1'b1);
      wait_done("after_rst");

      // back-to-back random operations, start on the cycle after done
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         issue(ra, rb, rc, ref_add(ra, rb, rc), 1'b1);
         wait_done("random");
      end

      repeat (4) @(negedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
